// File: rtl/bm_pkg.sv
// Shared definitions for the block-matching SAD min/second-min detector path.
package bm_pkg;

    // Detector pipeline depth; the detector itself is built against this value.
    localparam int BM_DET_LAT = 6;
    localparam int BM_COL_W   = 11;
    localparam int BM_ROW_W   = 10;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_RUN   = 3'd1,
        ST_GAP   = 3'd2,
        ST_DRAIN = 3'd3,
        ST_DONE  = 3'd4
    } state_t;

    // Tag that travels alongside each issued SAD vector.
    typedef struct packed {
        logic valid;
        logic sof;
        logic eof;
        logic sol;
        logic eol;
    } tag_t;

    localparam int TAG_W = $bits(tag_t);

endpackage

// File: rtl/bm_tag_delay.sv
// Fixed-depth delay line for the issue tag, matching the detector latency.
module bm_tag_delay
    import bm_pkg::*;
#(
    parameter int DEPTH = BM_DET_LAT
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [TAG_W-1:0] tag_in,
    output logic [TAG_W-1:0] tag_out,
    output logic             any_vld
);

    logic [DEPTH-1:0][TAG_W-1:0] pipe;

    // Shift one stage per cycle; reset flushes everything in flight.
    always_ff @(posedge clk) begin
        if (rst) begin
            pipe <= '0;
        end else begin
            pipe[0] <= tag_in;
            for (int i = 1; i < DEPTH; i++) pipe[i] <= pipe[i-1];
        end
    end

    // Any valid still in flight (valid is the tag MSB).
    always_comb begin
        any_vld = 1'b0;
        for (int i = 0; i < DEPTH; i++) any_vld = any_vld | pipe[i][TAG_W-1];
    end

    assign tag_out = pipe[DEPTH-1];

endmodule

// File: rtl/bm_det_sched.sv
// Issue scheduler feeding the SAD min/second-min detector: gates SAD vectors
// column by column, throttles on downstream FIFO credits, and regenerates
// row/frame markers aligned with the detector's valid-out.
module bm_det_sched
    import bm_pkg::*;
#(
    parameter int COL_W      = BM_COL_W,
    parameter int ROW_W      = BM_ROW_W,
    parameter int DET_LAT    = BM_DET_LAT,
    parameter int FIFO_DEPTH = 16,
    parameter int CRD_W      = 5
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             abort,
    input  logic [COL_W-1:0] cfg_width,
    input  logic [ROW_W-1:0] cfg_height,
    input  logic [3:0]       cfg_gap,
    input  logic             s_valid,
    output logic             s_ready,
    output logic             det_vin,
    input  logic             det_vout,
    input  logic             fifo_pop,
    output logic             o_sof,
    output logic             o_eof,
    output logic             o_sol,
    output logic             o_eol,
    output logic             busy,
    output logic             done,
    output logic             err_sync,
    output logic             err_credit
);

    localparam logic [CRD_W-1:0] CRD_FULL = CRD_W'(FIFO_DEPTH);

    state_t           state, state_nxt;
    logic [COL_W-1:0] col, width_q;
    logic [ROW_W-1:0] row, height_q;
    logic [3:0]       gap_q, gap_cnt;
    logic [CRD_W-1:0] credits;
    logic             issue, last_col, last_row, any_vld, clr_err;
    tag_t             tag_in, tail;
    logic [TAG_W-1:0] tail_bits;

    assign s_ready  = (state == ST_RUN) && (credits != '0);
    assign issue    = s_valid & s_ready;
    assign det_vin  = issue;
    assign last_col = (col == width_q - COL_W'(1));
    assign last_row = (row == height_q - ROW_W'(1));
    assign clr_err  = (state == ST_IDLE) && start;
    assign busy     = (state != ST_IDLE);

    // State register.
    always_ff @(posedge clk) begin
        if (rst) state <= ST_IDLE;
        else     state <= state_nxt;
    end

    // Next-state logic and the done pulse.
    always_comb begin
        state_nxt = state;
        done      = 1'b0;
        case (state)
            ST_IDLE: begin
                if (start)
                    state_nxt = (cfg_width == '0 || cfg_height == '0) ? ST_DONE : ST_RUN;
            end
            ST_RUN: begin
                // Abort still lets this cycle's issue through.
                if (abort || (issue && last_col && last_row)) state_nxt = ST_DRAIN;
                else if (issue && last_col)                  state_nxt = (gap_q != '0) ? ST_GAP : ST_RUN;
            end
            ST_GAP: begin
                if (abort)                state_nxt = ST_DRAIN;
                else if (gap_cnt == 4'd1) state_nxt = ST_RUN;
            end
            ST_DRAIN: begin
                if (!any_vld) state_nxt = ST_DONE;
            end
            ST_DONE: begin
                done      = 1'b1;
                state_nxt = ST_IDLE;
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    // Config latch, column/row position, gap timer, credits and sticky errors.
    always_ff @(posedge clk) begin
        if (rst) begin
            width_q    <= '0;
            height_q   <= '0;
            gap_q      <= '0;
            col        <= '0;
            row        <= '0;
            gap_cnt    <= '0;
            credits    <= CRD_FULL;
            err_sync   <= 1'b0;
            err_credit <= 1'b0;
        end else begin
            if (clr_err) begin
                width_q  <= cfg_width;
                height_q <= cfg_height;
                gap_q    <= cfg_gap;
                col      <= '0;
                row      <= '0;
            end else if (issue) begin
                if (last_col) begin
                    col <= '0;
                    if (!last_row) row <= row + ROW_W'(1);
                end else begin
                    col <= col + COL_W'(1);
                end
            end

            if (issue && last_col && !last_row) gap_cnt <= gap_q;
            else if (state == ST_GAP)           gap_cnt <= gap_cnt - 4'd1;

            // A pop with a simultaneous issue is a net zero, never an overflow.
            case ({issue, fifo_pop})
                2'b10:   credits <= credits - CRD_W'(1);
                2'b01:   if (credits != CRD_FULL) credits <= credits + CRD_W'(1);
                default: credits <= credits;
            endcase

            err_credit <= (err_credit & ~clr_err) | (fifo_pop & ~issue & (credits == CRD_FULL));
            err_sync   <= (err_sync & ~clr_err) | (det_vout != tail.valid);
        end
    end

    // Tag captured at issue; zero on idle cycles so the tail valid mirrors det_vout.
    always_comb begin
        tag_in = '0;
        if (issue) begin
            tag_in.valid = 1'b1;
            tag_in.sof   = (col == '0) && (row == '0);
            tag_in.eof   = last_col && last_row;
            tag_in.sol   = (col == '0);
            tag_in.eol   = last_col;
        end
    end

    bm_tag_delay #(.DEPTH(DET_LAT)) u_tag_delay (
        .clk     (clk),
        .rst     (rst),
        .tag_in  (tag_in),
        .tag_out (tail_bits),
        .any_vld (any_vld)
    );

    assign tail  = tag_t'(tail_bits);
    assign o_sof = tail.valid & tail.sof;
    assign o_eof = tail.valid & tail.eof;
    assign o_sol = tail.valid & tail.sol;
    assign o_eol = tail.valid & tail.eol;

endmodule
